// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter and scoreboard.
// Build option RF_ZERO_REG_EN: register NUM_REGS-1 becomes a hardwired zero register.
package rf_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int ZERO_REG = NUM_REGS - 1;

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Which writeback source currently holds priority when both request.
  typedef enum logic {
    SEL_ALU = 1'b0,
    SEL_MEM = 1'b1
  } arb_sel_e;

  // True only for the hardwired zero register, and only when that option is built in.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_REG_EN && (addr == ADDR_W'(ZERO_REG));
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request handshakes and the register-file write port bundle.
interface rf_write_arbiter_if;
  import rf_pkg::*;

  // Handshake: a request transfers on a cycle where valid && ready are both high;
  // ready is combinational from valid and never rises without it.
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              rf_write;
  logic [ADDR_W-1:0] rf_wrAddr;
  logic [DATA_W-1:0] rf_wrData;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_write, rf_wrAddr, rf_wrData
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_write, rf_wrAddr, rf_wrData
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: reservations set busy, committed writes clear it.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rsv_ready,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic [ADDR_W-1:0]   rdAddrA,
  input  logic [ADDR_W-1:0]   rdAddrB,
  output logic                hazA,
  output logic                hazB,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] keep_mask;
  logic [NUM_REGS-1:0] busy_next;

  // A register with a write still outstanding cannot be reserved again (WAW order).
  assign rsv_ready = rsv_valid && !busy_q[rsv_addr];

  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    keep_mask = '1;
    if (rsv_ready) set_mask[rsv_addr] = 1'b1;
    if (clr_en)    clr_mask[clr_addr] = 1'b1;
    if (ZERO_REG_EN) keep_mask[ZERO_REG] = 1'b0;
    // Clear first, then set: a same-edge reservation outlives the commit.
    busy_next = ((busy_q & ~clr_mask) | set_mask) & keep_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy = busy_q;
  assign hazA = busy_q[rdAddrA];
  assign hazB = busy_q[rdAddrB];

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the ALU and load writeback paths onto the single RF write port.
// Build option RF_ZERO_REG_EN: writes to register NUM_REGS-1 are accepted but suppressed.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  rf_write_arbiter_if.slave    wb,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic                 rsv_ready,
  input  logic [ADDR_W-1:0]    rdAddrA,
  input  logic [ADDR_W-1:0]    rdAddrB,
  output logic                 hazA,
  output logic                 hazB,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 rr_state
);

  wb_req_t  req0;
  wb_req_t  req1;
  wb_req_t  win;
  arb_sel_e rr_ptr;
  logic     grant0;
  logic     grant1;
  logic     commit;

  logic              write_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign req0 = '{valid: wb.req0_valid, addr: wb.req0_addr, data: wb.req0_data};
  assign req1 = '{valid: wb.req1_valid, addr: wb.req1_addr, data: wb.req1_data};

  always_comb begin
    grant0 = req0.valid && (!req1.valid || (rr_ptr == SEL_ALU));
    grant1 = req1.valid && (!req0.valid || (rr_ptr == SEL_MEM));
    win    = '0;
    if (grant0)      win = req0;
    else if (grant1) win = req1;
    // An accepted zero-register write still consumes the grant but never reaches the RF.
    commit = win.valid && !is_zero_reg(win.addr);
  end

  assign wb.req0_ready = grant0;
  assign wb.req1_ready = grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= SEL_ALU;
      write_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      // Priority moves to the loser only after a contested cycle.
      if (req0.valid && req1.valid) begin
        rr_ptr <= grant0 ? SEL_MEM : SEL_ALU;
      end
      write_q <= commit;
      if (commit) begin
        wr_addr_q <= win.addr;
        wr_data_q <= win.data;
      end
    end
  end

  assign wb.rf_write  = write_q;
  assign wb.rf_wrAddr = wr_addr_q;
  assign wb.rf_wrData = wr_data_q;
  assign rr_state     = rr_ptr;

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .clr_en    (write_q),
    .clr_addr  (wr_addr_q),
    .rdAddrA   (rdAddrA),
    .rdAddrB   (rdAddrB),
    .hazA      (hazA),
    .hazB      (hazB),
    .busy      (busy)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vectors, a queue-based reference model and literal pins.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;
  localparam int NR = NUM_REGS;

`ifdef RF_ZERO_REG_EN
  localparam bit ZMODE = 1'b1;
`else
  localparam bit ZMODE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_write_arbiter_if bus();
  logic          rsv_valid;
  logic [AW-1:0] rsv_addr;
  logic          rsv_ready;
  logic [AW-1:0] rdAddrA;
  logic [AW-1:0] rdAddrB;
  logic          hazA;
  logic          hazB;
  logic [NR-1:0] busy;
  logic          rr_state;

  rf_write_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (bus),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .rdAddrA   (rdAddrA),
    .rdAddrB   (rdAddrB),
    .hazA      (hazA),
    .hazB      (hazB),
    .busy      (busy),
    .rr_state  (rr_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Commits still owed to the RF, each {addr, data}; at most one is ever outstanding.
  logic [AW+DW-1:0] exp_q[$];
  bit               m_busy[NR];
  bit               m_fav;   // 0: ALU wins the next tie, 1: memory wins it

  function automatic bit is_zero(input logic [AW-1:0] a);
    return ZMODE && (a == AW'(NR - 1));
  endfunction

  function automatic logic [1:0] exp_grants();
    logic [1:0] g;
    g = 2'b00;
    if (bus.req0_valid && bus.req1_valid) g = m_fav ? 2'b10 : 2'b01;
    else if (bus.req0_valid)              g = 2'b01;
    else if (bus.req1_valid)              g = 2'b10;
    return g;
  endfunction

  function automatic logic [NR-1:0] m_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_fav = 1'b0;
      exp_q.delete();
    end else begin : model_step
      logic [1:0]       g;
      bit               racc;
      logic [AW+DW-1:0] w;
      g    = exp_grants();
      racc = rsv_valid && !m_busy[rsv_addr];
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        m_busy[w[AW+DW-1:DW]] = 1'b0;
      end
      if (racc && !is_zero(rsv_addr)) m_busy[rsv_addr] = 1'b1;
      if (bus.req0_valid && bus.req1_valid) m_fav = g[0];
      if (g[0] && !is_zero(bus.req0_addr)) exp_q.push_back({bus.req0_addr, bus.req0_data});
      if (g[1] && !is_zero(bus.req1_addr)) exp_q.push_back({bus.req1_addr, bus.req1_data});
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin : cmp_step
      logic [1:0] g;
      g = exp_grants();
      check("req0_ready", bus.req0_ready, g[0]);
      check("req1_ready", bus.req1_ready, g[1]);
      check("rf_write", bus.rf_write, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("rf_wrAddr", bus.rf_wrAddr, exp_q[0][AW+DW-1:DW]);
        check("rf_wrData", bus.rf_wrData, exp_q[0][DW-1:0]);
      end
      check("rsv_ready", rsv_ready, rsv_valid && !m_busy[rsv_addr]);
      check("hazA", hazA, m_busy[rdAddrA]);
      check("hazB", hazB, m_busy[rdAddrB]);
      check("busy", busy, m_busy_vec());
      check("rr_state", rr_state, m_fav);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    rdAddrA = '0; rdAddrB = '0;
  endtask

  task automatic drive(input bit v0, input int a0, input bit v1, input int a1,
                       input bit rv, input int ra, input int rda, input int rdb);
    step();
    bus.req0_valid = v0; bus.req0_addr = AW'(a0); bus.req0_data = 64'hA0A0_0000_0000_0000 + 64'(a0);
    bus.req1_valid = v1; bus.req1_addr = AW'(a1); bus.req1_data = 64'hB1B1_0000_0000_0000 + 64'(a1);
    rsv_valid = rv; rsv_addr = AW'(ra);
    rdAddrA = AW'(rda); rdAddrB = AW'(rdb);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle_inputs();
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("reset_busy", busy, '0);
    check("reset_rf_write", bus.rf_write, 1'b0);
    check("reset_rf_wrAddr", bus.rf_wrAddr, '0);
    check("reset_rf_wrData", bus.rf_wrData, '0);
    check("reset_rr_state", rr_state, 1'b0);

    // Lone ALU request.
    step();
    bus.req0_valid = 1'b1; bus.req0_addr = 5; bus.req0_data = 64'h1122334455667788;
    #1;
    check("alu_only_ready0", bus.req0_ready, 1'b1);
    check("alu_only_ready1", bus.req1_ready, 1'b0);
    step();
    bus.req0_valid = 1'b0;
    #1;
    check("alu_only_write", bus.rf_write, 1'b1);
    check("alu_only_addr", bus.rf_wrAddr, 5);
    check("alu_only_data", bus.rf_wrData, 64'h1122334455667788);
    check("alu_only_ready1_b", bus.req1_ready, 1'b0);
    step();
    #1;
    check("alu_only_pulse_end", bus.rf_write, 1'b0);

    // Contention right after reset: grants alternate starting with ALU.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 1; bus.req0_data = 64'hA1;
    bus.req1_valid = 1'b1; bus.req1_addr = 2; bus.req1_data = 64'hB2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_grant0", bus.req0_ready, (k % 2) == 0);
      check("rr_grant1", bus.req1_ready, (k % 2) == 1);
      step();
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      check("rr_wraddr", bus.rf_wrAddr, ((k % 2) == 0) ? 1 : 2);
    end

    // WAW: a second reservation of a busy register is refused until the write lands.
    step();
    rsv_valid = 1'b1; rsv_addr = 7;
    #1;
    check("rsv7_first", rsv_ready, 1'b1);
    step();
    #1;
    check("rsv7_second", rsv_ready, 1'b0);
    check("rsv7_busy", busy[7], 1'b1);
    step();
    rsv_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 7; bus.req0_data = 64'h77;
    step();
    bus.req0_valid = 1'b0;
    #1;
    check("wr7_inflight_busy", busy[7], 1'b1);
    step();
    #1;
    check("wr7_cleared", busy[7], 1'b0);
    rsv_valid = 1'b1; rsv_addr = 7;
    #1;
    check("rsv7_retry", rsv_ready, 1'b1);
    step();
    rsv_valid = 1'b0;
    #1;
    check("rsv7_retry_busy", busy[7], 1'b1);

    // Reservation on the same edge as a commit to the same register: set wins.
    step();
    bus.req0_valid = 1'b1; bus.req0_addr = 9; bus.req0_data = 64'h99;
    step();
    bus.req0_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 9; rdAddrA = 9;
    #1;
    check("rsv9_same_edge_ready", rsv_ready, 1'b1);
    check("rsv9_commit_addr", bus.rf_wrAddr, 9);
    step();
    rsv_valid = 1'b0;
    #1;
    check("rsv9_busy_kept", busy[9], 1'b1);
    check("rsv9_hazA", hazA, 1'b1);

    // Asynchronous reset while a write to a busy register is in flight.
    step();
    rsv_valid = 1'b1; rsv_addr = 3;
    step();
    rsv_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 3; bus.req0_data = 64'h33;
    bus.req1_valid = 1'b1; bus.req1_addr = 3; bus.req1_data = 64'h44;
    #1;
    check("arst_pre_grant0", bus.req0_ready, 1'b1);
    step();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1;
    check("arst_pre_write", bus.rf_write, 1'b1);
    check("arst_pre_busy3", busy[3], 1'b1);
    check("arst_pre_rr", rr_state, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("arst_write", bus.rf_write, 1'b0);
    check("arst_addr", bus.rf_wrAddr, '0);
    check("arst_data", bus.rf_wrData, '0);
    check("arst_busy", busy, '0);
    check("arst_rr", rr_state, 1'b0);
    step();
    reset = 1'b0;

    // Register 31: zero register only when built with the option.
    step();
    bus.req0_valid = 1'b1; bus.req0_addr = 31; bus.req0_data = 64'hDEAD_BEEF;
    #1;
    check("x31_ready", bus.req0_ready, 1'b1);
    step();
    bus.req0_valid = 1'b0;
    #1;
    check("x31_write", bus.rf_write, !ZMODE);
    step();
    rsv_valid = 1'b1; rsv_addr = 31;
    #1;
    check("x31_rsv_ready", rsv_ready, 1'b1);
    step();
    rsv_valid = 1'b0; rdAddrB = 31;
    #1;
    check("x31_busy", busy[31], !ZMODE);
    check("x31_hazB", hazB, !ZMODE);

    // Mixed vectors, checked cycle by cycle against the model.
    drive(1, 4, 1, 6, 1, 4, 4, 6);
    drive(1, 4, 1, 6, 1, 6, 4, 6);
    drive(0, 0, 1, 8, 1, 8, 8, 4);
    drive(1, 10, 0, 0, 1, 10, 10, 8);
    drive(1, 11, 1, 12, 1, 11, 11, 12);
    drive(1, 12, 1, 11, 0, 0, 12, 11);
    drive(0, 0, 0, 0, 1, 4, 4, 10);
    drive(1, 31, 1, 30, 1, 30, 31, 30);
    drive(0, 0, 1, 31, 1, 31, 31, 30);
    drive(1, 20, 1, 21, 1, 20, 20, 21);
    drive(0, 0, 0, 0, 0, 0, 20, 21);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
